// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000-style bus initiator: FSM state codes,
// E-clock timing defaults and byte-enable encodings.
package m68k_bus_pkg;

  localparam int E_LOW_DEF   = 6;
  localparam int E_HIGH_DEF  = 4;
  localparam int TIMEOUT_DEF = 64;

  typedef logic [3:0] bus_state_t;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_ADDR  = 4'd1;
  localparam logic [3:0] ST_WDS   = 4'd2;
  localparam logic [3:0] ST_WAIT  = 4'd3;
  localparam logic [3:0] ST_DATA  = 4'd4;
  localparam logic [3:0] ST_VSYNC = 4'd5;
  localparam logic [3:0] ST_VEH   = 4'd6;
  localparam logic [3:0] ST_TERM  = 4'd7;
  localparam logic [3:0] ST_RECOV = 4'd8;

  localparam logic [1:0] BE_LOWER = 2'b01;
  localparam logic [1:0] BE_UPPER = 2'b10;
  localparam logic [1:0] BE_WORD  = 2'b11;

  // Active-low {UDS, LDS} for a byte-enable pair while data strobes are on.
  function automatic logic [1:0] ds_strobes_n(input logic [1:0] be, input logic active);
    logic [1:0] ds_n;
    ds_n[1] = !(active && (|(be & BE_UPPER)));
    ds_n[0] = !(active && (|(be & BE_LOWER)));
    return ds_n;
  endfunction

endpackage

// File: rtl/m68k_bus_initiator_eclk.sv
// Free-running 6800 E clock: counts 0..E_LOW+E_HIGH-1, E high for the upper
// E_HIGH counts. Exposes the current count for VMA cycle alignment.
module m68k_eclk_gen
  import m68k_bus_pkg::*;
#(
  parameter int E_LOW  = E_LOW_DEF,
  parameter int E_HIGH = E_HIGH_DEF,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             e,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(E_LOW + E_HIGH - 1);
  localparam logic [CNT_W-1:0] HIGH_AT  = CNT_W'(E_LOW);

  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

  // E is registered from the next count so it lines up with cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      e   <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      e   <= (cnt_nxt >= HIGH_AT);
    end
  end

endmodule

// File: rtl/m68k_bus_initiator.sv
// 68000 asynchronous bus master: request/ack front end to AS/UDS/LDS/RW cycles,
// DTACK/VPA/BERR termination. Optional watchdog under macro BUS_TIMEOUT_EN.
module m68k_bus_initiator
  import m68k_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int E_LOW          = E_LOW_DEF,
  parameter int E_HIGH         = E_HIGH_DEF
) (
  input  logic        CLK7M,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        REQ_RW,
  input  logic [22:0] REQ_A,
  input  logic [1:0]  REQ_BE,
  input  logic [15:0] REQ_WDATA,
  output logic        ACK,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic [22:0] A,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  input  logic [15:0] D_IN,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  input  logic        DTACK,
  input  logic        VPA,
  input  logic        BERR,
  output logic        E,
  output logic        VMA,
  output logic        BUSY
);

  localparam int ECW = $clog2(E_LOW + E_HIGH);
  localparam logic [ECW-1:0] E_LAST = ECW'(E_LOW + E_HIGH - 1);

  bus_state_t       state;
  bus_state_t       state_nxt;
  logic             dtack_s;
  logic             vpa_s;
  logic             berr_s;
  logic             rw_q;
  logic [1:0]       be_q;
  logic             err_pend;
  logic             err_set;
  logic             rd_cap;
  logic             accept;
  logic             rw_nxt;
  logic [1:0]       be_nxt;
  logic             bus_on;
  logic             ds_on;
  logic             tmo_hit;
  logic [ECW-1:0]   e_cnt;

  m68k_eclk_gen #(
    .E_LOW  (E_LOW),
    .E_HIGH (E_HIGH),
    .CNT_W  (ECW)
  ) u_eclk (
    .clk (CLK7M),
    .rst (RESET),
    .e   (E),
    .cnt (e_cnt)
  );

`ifdef BUS_TIMEOUT_EN
  localparam logic [6:0] TMO_LAST = 7'(TIMEOUT_CYCLES - 1);
  logic [6:0] tmo_cnt;

  always_ff @(posedge CLK7M or posedge RESET) begin
    if (RESET) begin
      tmo_cnt <= '0;
    end else if (state == ST_ADDR) begin
      tmo_cnt <= '0;
    end else if (state == ST_WAIT || state == ST_VSYNC || state == ST_VEH) begin
      tmo_cnt <= tmo_cnt + 7'd1;
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  assign accept = (state == ST_IDLE) && REQ;
  assign rw_nxt = accept ? REQ_RW : rw_q;
  assign be_nxt = accept ? REQ_BE : be_q;

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    rd_cap    = 1'b0;
    case (state)
      ST_IDLE:  if (REQ) state_nxt = ST_ADDR;
      ST_ADDR:  state_nxt = rw_q ? ST_WAIT : ST_WDS;
      ST_WDS:   state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!berr_s || tmo_hit) begin
          err_set   = 1'b1;
          state_nxt = ST_TERM;
        end else if (!dtack_s) begin
          state_nxt = ST_DATA;
        end else if (!vpa_s) begin
          state_nxt = ST_VSYNC;
        end
      end
      ST_DATA: begin
        rd_cap    = rw_q;
        state_nxt = ST_TERM;
      end
      // Enter VEH as the counter wraps so VMA covers one whole E period.
      ST_VSYNC: begin
        if (tmo_hit) begin
          err_set   = 1'b1;
          state_nxt = ST_TERM;
        end else if (e_cnt == E_LAST) begin
          state_nxt = ST_VEH;
        end
      end
      ST_VEH: begin
        err_set = !berr_s || tmo_hit;
        if (tmo_hit) begin
          state_nxt = ST_TERM;
        end else if (e_cnt == E_LAST) begin
          rd_cap    = rw_q && !(err_pend || err_set);
          state_nxt = ST_TERM;
        end
      end
      ST_TERM:  state_nxt = ST_RECOV;
      ST_RECOV: if (dtack_s && vpa_s && berr_s) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they are glitch-free.
  assign bus_on = (state_nxt == ST_ADDR) || (state_nxt == ST_WDS) ||
                  (state_nxt == ST_WAIT) || (state_nxt == ST_DATA) ||
                  (state_nxt == ST_VSYNC) || (state_nxt == ST_VEH);
  assign ds_on  = bus_on && (rw_nxt || (state_nxt != ST_ADDR));

  always_ff @(posedge CLK7M or posedge RESET) begin
    if (RESET) begin
      dtack_s  <= 1'b1;
      vpa_s    <= 1'b1;
      berr_s   <= 1'b1;
      state    <= ST_IDLE;
      rw_q     <= 1'b1;
      be_q     <= 2'b00;
      err_pend <= 1'b0;
      A        <= '0;
      D_OUT    <= '0;
      RDATA    <= '0;
      AS       <= 1'b1;
      UDS      <= 1'b1;
      LDS      <= 1'b1;
      VMA      <= 1'b1;
      RW       <= 1'b1;
      D_OE     <= 1'b0;
      ACK      <= 1'b0;
      ERR      <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      dtack_s <= DTACK;
      vpa_s   <= VPA;
      berr_s  <= BERR;
      state   <= state_nxt;
      if (accept) begin
        A     <= REQ_A;
        D_OUT <= REQ_WDATA;
        rw_q  <= REQ_RW;
        be_q  <= REQ_BE;
      end
      if (state == ST_ADDR) begin
        err_pend <= 1'b0;
      end else if (err_set) begin
        err_pend <= 1'b1;
      end
      if (rd_cap) begin
        RDATA <= D_IN;
      end
      AS         <= !bus_on;
      {UDS, LDS} <= ds_strobes_n(be_nxt, ds_on);
      RW         <= !(bus_on && !rw_nxt);
      D_OE       <= bus_on && !rw_nxt;
      VMA        <= (state_nxt != ST_VEH);
      ACK        <= (state_nxt == ST_TERM);
      ERR        <= (state_nxt == ST_TERM) && (err_pend || err_set);
      BUSY       <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Directed bench for m68k_bus_initiator: DTACK, VPA and BERR cycles, latency,
// reset behaviour and the BUS_TIMEOUT_EN watchdog.
module tb_m68k_bus_initiator;
  import m68k_bus_pkg::*;

  logic        CLK7M;
  logic        RESET;
  logic        REQ;
  logic        REQ_RW;
  logic [22:0] REQ_A;
  logic [1:0]  REQ_BE;
  logic [15:0] REQ_WDATA;
  logic        ACK;
  logic        ERR;
  logic [15:0] RDATA;
  logic [22:0] A;
  logic [15:0] D_OUT;
  logic        D_OE;
  logic [15:0] D_IN;
  logic        AS;
  logic        UDS;
  logic        LDS;
  logic        RW;
  logic        DTACK;
  logic        VPA;
  logic        BERR;
  logic        E;
  logic        VMA;
  logic        BUSY;

  int checks = 0;
  int errors = 0;
  int ecnt;

  m68k_bus_initiator #(
    .TIMEOUT_CYCLES (64),
    .E_LOW          (6),
    .E_HIGH         (4)
  ) dut (
    .CLK7M     (CLK7M),
    .RESET     (RESET),
    .REQ       (REQ),
    .REQ_RW    (REQ_RW),
    .REQ_A     (REQ_A),
    .REQ_BE    (REQ_BE),
    .REQ_WDATA (REQ_WDATA),
    .ACK       (ACK),
    .ERR       (ERR),
    .RDATA     (RDATA),
    .A         (A),
    .D_OUT     (D_OUT),
    .D_OE      (D_OE),
    .D_IN      (D_IN),
    .AS        (AS),
    .UDS       (UDS),
    .LDS       (LDS),
    .RW        (RW),
    .DTACK     (DTACK),
    .VPA       (VPA),
    .BERR      (BERR),
    .E         (E),
    .VMA       (VMA),
    .BUSY      (BUSY)
  );

  initial CLK7M = 1'b0;
  always #5 CLK7M = ~CLK7M;

  // Reference E counter: 0..9 wrapping, cleared by reset.
  always @(posedge CLK7M or posedge RESET) begin
    if (RESET) ecnt <= 0;
    else       ecnt <= (ecnt == 9) ? 0 : ecnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK7M);
    #1;
  endtask

  task automatic wait_ack(input int max_ticks, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < max_ticks) begin
      tick();
      n++;
      if (ACK === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; REQ = 1'b0; REQ_RW = 1'b1; REQ_A = '0; REQ_BE = BE_WORD;
    REQ_WDATA = '0; D_IN = '0; DTACK = 1'b1; VPA = 1'b1; BERR = 1'b1;
    #12;
    checks++; if ({AS, UDS, LDS, VMA, RW} !== 5'b11111) begin errors++; $display("FAIL rst_strobes: got %b required 11111", {AS, UDS, LDS, VMA, RW}); end
    checks++; if ({D_OE, ACK, ERR, BUSY, E} !== 5'b00000) begin errors++; $display("FAIL rst_ctrl: got %b required 00000", {D_OE, ACK, ERR, BUSY, E}); end
    checks++; if (A !== 23'h0 || D_OUT !== 16'h0 || RDATA !== 16'h0) begin errors++; $display("FAIL rst_data: got A=%h D_OUT=%h RDATA=%h required zeros", A, D_OUT, RDATA); end
    @(negedge CLK7M);
    RESET = 1'b0;
  endtask

  task automatic test_eclk();
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (E !== (ecnt >= 6)) begin errors++; $display("FAIL eclk: count %0d got E=%b required %b", ecnt, E, (ecnt >= 6)); end
    end
  endtask

  task automatic test_read_dtack();
    int n; bit seen;
    REQ_RW = 1'b1; REQ_A = 23'h7C0000; REQ_BE = BE_WORD; D_IN = 16'h4AFC; REQ = 1'b1;
    tick();
    checks++; if ({AS, UDS, LDS} !== 3'b000) begin errors++; $display("FAIL rd_strobes: got %b required 000", {AS, UDS, LDS}); end
    checks++; if (A !== 23'h7C0000 || RW !== 1'b1 || BUSY !== 1'b1 || D_OE !== 1'b0) begin errors++; $display("FAIL rd_addr: got A=%h RW=%b BUSY=%b D_OE=%b required 7c0000 1 1 0", A, RW, BUSY, D_OE); end
    tick();
    DTACK = 1'b0;
    wait_ack(10, n, seen);
    checks++; if (!seen || n != 3) begin errors++; $display("FAIL rd_ack_time: got seen=%b ticks=%0d required 1 3", seen, n); end
    checks++; if (RDATA !== 16'h4AFC || ERR !== 1'b0) begin errors++; $display("FAIL rd_data: got %h err=%b required 4afc 0", RDATA, ERR); end
    checks++; if ({AS, UDS, LDS} !== 3'b111) begin errors++; $display("FAIL rd_term_strobes: got %b required 111", {AS, UDS, LDS}); end
    REQ = 1'b0; DTACK = 1'b1;
    tick();
    checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL rd_ack_pulse: got %b required 0", ACK); end
    repeat (3) tick();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rd_idle: got BUSY=%b required 0", BUSY); end
  endtask

  task automatic test_write_lds();
    int n; bit seen; bit drv_ok;
    REQ_RW = 1'b0; REQ_A = 23'h060000; REQ_BE = BE_LOWER; REQ_WDATA = 16'h0055; REQ = 1'b1;
    tick();
    checks++; if ({AS, UDS, LDS} !== 3'b011) begin errors++; $display("FAIL wr_addr_strobes: got %b required 011", {AS, UDS, LDS}); end
    checks++; if (RW !== 1'b0 || D_OE !== 1'b1 || D_OUT !== 16'h0055 || A !== 23'h060000) begin errors++; $display("FAIL wr_addr: got RW=%b D_OE=%b D_OUT=%h A=%h", RW, D_OE, D_OUT, A); end
    REQ = 1'b0;
    tick();
    checks++; if ({UDS, LDS, D_OE} !== 3'b101) begin errors++; $display("FAIL wr_wds: got %b required 101", {UDS, LDS, D_OE}); end
    DTACK = 1'b0;
    n = 0; seen = 1'b0; drv_ok = 1'b1;
    while (!seen && n < 10) begin
      tick();
      n++;
      if (ACK === 1'b1) seen = 1'b1;
      else if (D_OE !== 1'b1 || RW !== 1'b0 || LDS !== 1'b0) drv_ok = 1'b0;
    end
    checks++; if (!seen || n != 3) begin errors++; $display("FAIL wr_ack_time: got seen=%b ticks=%0d required 1 3", seen, n); end
    checks++; if (!drv_ok) begin errors++; $display("FAIL wr_drive: got drive dropped before TERM required held"); end
    checks++; if ({ERR, D_OE, RW, AS, LDS} !== 5'b00111) begin errors++; $display("FAIL wr_term: got %b required 00111", {ERR, D_OE, RW, AS, LDS}); end
    DTACK = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_vpa_read();
    int n; int vma_tick; int vma_cnt; int ack_cnt; bit vma_seen; bit seen;
    VPA = 1'b0; D_IN = 16'h00FF; REQ_RW = 1'b1; REQ_A = 23'h5FF000; REQ_BE = BE_LOWER; REQ = 1'b1;
    tick();
    checks++; if ({AS, UDS, LDS} !== 3'b010) begin errors++; $display("FAIL vpa_strobes: got %b required 010", {AS, UDS, LDS}); end
    n = 0; vma_seen = 1'b0; seen = 1'b0; vma_tick = 0; vma_cnt = -1; ack_cnt = -1;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (VMA === 1'b0 && !vma_seen) begin vma_seen = 1'b1; vma_tick = n; vma_cnt = ecnt; end
      if (ACK === 1'b1) begin seen = 1'b1; ack_cnt = ecnt; end
    end
    checks++; if (!vma_seen || vma_cnt != 0) begin errors++; $display("FAIL vpa_vma_align: got seen=%b count=%0d required 1 0", vma_seen, vma_cnt); end
    checks++; if (!seen || (n - vma_tick) != 10 || ack_cnt != 0) begin errors++; $display("FAIL vpa_ack_time: got seen=%b span=%0d count=%0d required 1 10 0", seen, n - vma_tick, ack_cnt); end
    checks++; if (RDATA !== 16'h00FF || ERR !== 1'b0) begin errors++; $display("FAIL vpa_data: got %h err=%b required 00ff 0", RDATA, ERR); end
    checks++; if (AS !== 1'b1 || VMA !== 1'b1) begin errors++; $display("FAIL vpa_term: got AS=%b VMA=%b required 1 1", AS, VMA); end
    REQ = 1'b0; VPA = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_berr_dtack();
    int n; bit seen;
    D_IN = 16'hDEAD; REQ_RW = 1'b1; REQ_A = 23'h000400; REQ_BE = BE_WORD; REQ = 1'b1;
    tick();
    tick();
    DTACK = 1'b0; BERR = 1'b0;
    wait_ack(10, n, seen);
    checks++; if (!seen || n != 2) begin errors++; $display("FAIL berr_ack_time: got seen=%b ticks=%0d required 1 2", seen, n); end
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL berr_err: got %b required 1", ERR); end
    checks++; if (RDATA !== 16'h00FF) begin errors++; $display("FAIL berr_rdata: got %h required 00ff", RDATA); end
    REQ = 1'b0; DTACK = 1'b1; BERR = 1'b1;
    tick();
    checks++; if (ERR !== 1'b0 || ACK !== 1'b0) begin errors++; $display("FAIL berr_pulse: got ERR=%b ACK=%b required 0 0", ERR, ACK); end
    repeat (3) tick();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL berr_idle: got BUSY=%b required 0", BUSY); end
  endtask

  task automatic test_zero_wait();
    int n; bit seen;
    DTACK = 1'b0;
    tick(); tick();
    D_IN = 16'h1357; REQ_RW = 1'b1; REQ_A = 23'h000010; REQ_BE = BE_WORD; REQ = 1'b1;
    wait_ack(10, n, seen);
    checks++; if (!seen || n != 4) begin errors++; $display("FAIL zw_read_latency: got seen=%b ticks=%0d required 1 4", seen, n); end
    checks++; if (RDATA !== 16'h1357) begin errors++; $display("FAIL zw_read_data: got %h required 1357", RDATA); end
    REQ = 1'b0; DTACK = 1'b1;
    repeat (4) tick();
    DTACK = 1'b0;
    tick(); tick();
    REQ_RW = 1'b0; REQ_WDATA = 16'hBEEF; REQ_BE = BE_UPPER; REQ = 1'b1;
    wait_ack(10, n, seen);
    checks++; if (!seen || n != 5) begin errors++; $display("FAIL zw_write_latency: got seen=%b ticks=%0d required 1 5", seen, n); end
    checks++; if (RDATA !== 16'h1357 || D_OUT !== 16'hBEEF) begin errors++; $display("FAIL zw_write_data: got RDATA=%h D_OUT=%h required 1357 beef", RDATA, D_OUT); end
    REQ = 1'b0; DTACK = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_cycle();
    int n; bit seen; bit ack_seen;
    REQ_RW = 1'b1; REQ_A = 23'h001000; REQ_BE = BE_WORD; REQ = 1'b1;
    tick(); tick(); tick();
    checks++; if (AS !== 1'b0 || BUSY !== 1'b1) begin errors++; $display("FAIL mr_pre: got AS=%b BUSY=%b required 0 1", AS, BUSY); end
    #3 RESET = 1'b1;
    #1;
    checks++; if ({AS, UDS, LDS} !== 3'b111) begin errors++; $display("FAIL mr_strobes: got %b required 111", {AS, UDS, LDS}); end
    checks++; if (BUSY !== 1'b0 || ACK !== 1'b0) begin errors++; $display("FAIL mr_ctrl: got BUSY=%b ACK=%b required 0 0", BUSY, ACK); end
    REQ = 1'b0; DTACK = 1'b0;
    @(posedge CLK7M);
    @(negedge CLK7M);
    RESET = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ACK !== 1'b0) ack_seen = 1'b1;
    end
    checks++; if (ack_seen) begin errors++; $display("FAIL mr_no_ack: got ACK pulse after reset required none"); end
    D_IN = 16'hA5C3; REQ_RW = 1'b1; REQ = 1'b1;
    wait_ack(10, n, seen);
    checks++; if (!seen || n != 4 || RDATA !== 16'hA5C3 || ERR !== 1'b0) begin errors++; $display("FAIL mr_next: got seen=%b ticks=%0d RDATA=%h ERR=%b required 1 4 a5c3 0", seen, n, RDATA, ERR); end
    REQ = 1'b0; DTACK = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_timeout();
    int n; bit seen;
    DTACK = 1'b1; VPA = 1'b1; BERR = 1'b1;
    REQ_RW = 1'b1; REQ_A = 23'h3FFFFF; REQ_BE = BE_WORD; REQ = 1'b1;
`ifdef BUS_TIMEOUT_EN
    wait_ack(80, n, seen);
    checks++; if (!seen || n != 66) begin errors++; $display("FAIL tmo_ack_time: got seen=%b ticks=%0d required 1 66", seen, n); end
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b required 1", ERR); end
    REQ = 1'b0;
    repeat (4) tick();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL tmo_idle: got BUSY=%b required 0", BUSY); end
`else
    wait_ack(100, n, seen);
    checks++; if (seen) begin errors++; $display("FAIL hang_no_ack: got ACK after %0d ticks required none", n); end
    checks++; if (BUSY !== 1'b1 || AS !== 1'b0) begin errors++; $display("FAIL hang_busy: got BUSY=%b AS=%b required 1 0", BUSY, AS); end
    REQ = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_eclk();
    test_read_dtack();
    test_write_lds();
    test_vpa_read();
    test_berr_dtack();
    test_zero_wait();
    test_reset_mid_cycle();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m68k_bus_initiator.md
Name: m68k_bus_initiator

Overview:
- Synthesizable 68000-style asynchronous bus master for the motherboard side of the accelerator. It runs on CLK7M.
- Converts a single-transfer request/acknowledge interface into AS/UDS/LDS/RW cycles toward the Amiga bus.
- Terminates on DTACK, on VPA (6800 E/VMA cycle) or on BERR. It also generates the E clock used for 6800 cycles.

Parameters:
- TIMEOUT_CYCLES, 64: CLK7M cycles from AS assertion to forced error (only with BUS_TIMEOUT_EN).
- E_LOW, 6: CLK7M cycles E is low per E period.
- E_HIGH, 4: CLK7M cycles E is high per E period.

Ports:
- CLK7M in 1: bus clock; all logic on rising edge.
- RESET in 1: asynchronous, active-high reset.
- REQ in 1: transfer request; held with its operands until ACK.
- REQ_RW in 1: 1=read, 0=write.
- REQ_A in 23: word address A[23:1].
- REQ_BE in 2: byte enables {upper,lower}; 2'b00 is illegal.
- REQ_WDATA in 16: write data.
- ACK out 1: one-cycle pulse at cycle end.
- ERR out 1: valid with ACK; 1 = bus error/timeout.
- RDATA out 16: read data; valid with ACK, held until next ACK.
- A out 23: bus address.
- D_OUT out 16: bus write data.
- D_OE out 1: data driver enable.
- D_IN in 16: bus read data.
- AS, UDS, LDS out 1: strobes, active-low.
- RW out 1: 1=read.
- DTACK, VPA, BERR in 1: active-low terminations, asynchronous to state.
- E out 1: 6800 E clock.
- VMA out 1: active-low.
- BUSY out 1: high from cycle start until IDLE.

Behaviour:
- Reset values: AS=UDS=LDS=VMA=1, RW=1, D_OE=0, ACK=0, ERR=0, BUSY=0, A=0, D_OUT=0, RDATA=0, E=0, E counter=0.
- Input sync: DTACK, VPA and BERR each pass one sync flop (DTs, VPs, BEs). All decisions use the synced versions.
- E generator:
  - Free-running counter 0..E_LOW+E_HIGH-1, wrapping to 0.
  - E=1 when counter >= E_LOW; E is registered.
  - Runs independent of cycles and is reset only by RESET.
- State machine:
  - IDLE:
    - BUSY=0.
    - On REQ: latch REQ_* into A, RW, D_OUT and a BE register; go to ADDR.
  - ADDR:
    - AS=0, BUSY=1.
    - Read: UDS/LDS asserted per BE in the same cycle.
    - Write: D_OE=1, RW=0; go to WDS.
    - Read: go to WAIT.
  - WDS (write only): UDS/LDS asserted per BE; go to WAIT.
  - WAIT: priority BEs==0 > DTs==0 > VPs==0.
    - BERR: go to TERM with ERR pending.
    - DTACK: go to DATA.
    - VPA: go to VSYNC.
    - Otherwise stay.
  - DATA: if read, RDATA<=D_IN; go to TERM.
  - VSYNC: wait until E counter==0, then VMA=0; go to VEH.
  - VEH:
    - Wait for the last E-high count (counter==E_LOW+E_HIGH-1).
    - Read: RDATA<=D_IN. Then go to TERM.
    - BERR seen here also sets ERR pending.
  - TERM:
    - AS=UDS=LDS=VMA=1, D_OE=0, RW=1.
    - ACK=1 for exactly this cycle; ERR=pending.
    - Go to RECOV.
  - RECOV:
    - Stay until DTs==1, VPs==1 and BEs==1; then go to IDLE.
    - A new REQ is not accepted before IDLE.
- Latency: a zero-wait read with DTACK already low at the sync flop acks 4 cycles after REQ is sampled (ADDR, WAIT, DATA, TERM). A write takes 5.
- Simultaneous events:
  - BERR with DTACK: BERR wins, and RDATA is not updated.
  - REQ deasserting mid-cycle is ignored; the cycle completes.
- Reset mid-cycle: all strobes are negated immediately (asynchronous) and the state returns to IDLE with no ACK.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - A 7-bit counter clears in ADDR and increments in WAIT, VSYNC and VEH.
  - Reaching TIMEOUT_CYCLES forces TERM with ERR=1.
  - A real BERR in the same cycle behaves identically.
- Undefined: no counter; WAIT may hang forever.

Decomposition:
- Shared package m68k_bus_pkg holds:
  - state enum: IDLE, ADDR, WDS, WAIT, DATA, VSYNC, VEH, TERM, RECOV;
  - constants E_LOW/E_HIGH defaults;
  - BE encoding constants.
- One sub-module, m68k_eclk_gen: E counter, E output, and the current-count output used by VSYNC/VEH.

Test Plan:
- Read 0xF80000, BE=11; model returns 0x4AFC with DTACK low 2 cycles after AS -> RDATA=0x4AFC, ERR=0, UDS/LDS low with AS, ACK single cycle.
- Write 0x0C0001, lower byte only (BE=01), data 0x0055 -> UDS stays high, LDS falls one cycle after AS, D_OE high from ADDR to TERM, RW=0, ACK with ERR=0.
- Read 0xBFE001 with VPA response and D_IN=0x00FF -> VMA asserts at E counter 0, RDATA=0x00FF latched at counter 9, ACK one cycle later, AS negated in TERM.
- BERR and DTACK asserted in the same cycle during WAIT -> ACK with ERR=1, RDATA unchanged from previous value.
- With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=64, no response -> ACK with ERR=1 exactly 64 WAIT cycles after ADDR; without the macro, BUSY stays high.
- RESET pulse while in WAIT -> AS/UDS/LDS=1 within the reset edge, no ACK, next REQ completes normally.
